// File: rtl/program_counter_seq_if.sv
// Control and status bundle between instruction decode and the program-counter unit.
// Decode is the master and drives the controls; the PC unit is the slave and reports the address and stack status.
interface program_counter_seq_if #(
    parameter int WIDTH       = 8,
    parameter int STACK_DEPTH = 4,
    parameter int OFS_WIDTH   = 8
);
    localparam int SPW = $clog2(STACK_DEPTH) + 1;

    logic                 stall;
    logic                 branch_en;
    logic                 branch_cond;
    logic [OFS_WIDTH-1:0] branch_offset;
    logic                 jump_en;
    logic                 call_en;
    logic                 ret_en;
    logic [WIDTH-1:0]     jump_target;

    logic [WIDTH-1:0]     PC;
    logic [WIDTH-1:0]     pc_plus1;
    logic [SPW-1:0]       sp;
    logic                 stack_full;
    logic                 stack_empty;
    logic                 err_overflow;
    logic                 err_underflow;

    modport master (
        output stall, branch_en, branch_cond, branch_offset,
               jump_en, call_en, ret_en, jump_target,
        input  PC, pc_plus1, sp, stack_full, stack_empty,
               err_overflow, err_underflow
    );

    modport slave (
        input  stall, branch_en, branch_cond, branch_offset,
               jump_en, call_en, ret_en, jump_target,
        output PC, pc_plus1, sp, stack_full, stack_empty,
               err_overflow, err_underflow
    );
endinterface

// File: rtl/program_counter_seq.sv
// Program counter with increment, PC-relative branch, absolute jump, and call/return through a small return-address stack.
// Next-PC priority: stall, return, call, jump, taken branch, increment.
module program_counter_seq #(
    parameter int               WIDTH        = 8,
    parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
    parameter int               STACK_DEPTH  = 4,
    parameter int               OFS_WIDTH    = 8
) (
    input  logic                  clock_reg,
    input  logic                  reset,
    program_counter_seq_if.slave  pcIf
);
    localparam int SPW  = $clog2(STACK_DEPTH) + 1;
    localparam int PTRW = $clog2(STACK_DEPTH);

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [SPW-1:0]   sp_q, sp_d;
    logic             errOverflow_q, errOverflow_d;
    logic             errUnderflow_q, errUnderflow_d;
    logic [WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [WIDTH-1:0] pcPlus1;
    logic [WIDTH-1:0] offsetExt;
    logic [PTRW-1:0]  pushIdx;
    logic [PTRW-1:0]  popIdx;
    logic             pushEn;
    logic             stackFull;
    logic             stackEmpty;

    assign pcPlus1    = pc_q + WIDTH'(1);
    assign offsetExt  = WIDTH'($signed(pcIf.branch_offset));
    assign stackFull  = (sp_q == SPW'(STACK_DEPTH));
    assign stackEmpty = (sp_q == '0);
    assign pushIdx    = sp_q[PTRW-1:0];
    // When sp equals STACK_DEPTH the low bits are zero, so subtracting one still lands on the top entry.
    assign popIdx     = sp_q[PTRW-1:0] - PTRW'(1);

    always_comb begin
        pc_d           = pc_q;
        sp_d           = sp_q;
        errOverflow_d  = errOverflow_q;
        errUnderflow_d = errUnderflow_q;
        pushEn         = 1'b0;
        if (!pcIf.stall) begin
            if (pcIf.ret_en) begin
                if (!stackEmpty) begin
                    pc_d = stack_q[popIdx];
                    sp_d = sp_q - SPW'(1);
                end else begin
                    pc_d           = pcPlus1;
                    errUnderflow_d = 1'b1;
                end
            end else if (pcIf.call_en) begin
                pc_d = pcIf.jump_target;
                if (!stackFull) begin
                    pushEn = 1'b1;
                    sp_d   = sp_q + SPW'(1);
                end else begin
                    errOverflow_d = 1'b1;
                end
            end else if (pcIf.jump_en) begin
                pc_d = pcIf.jump_target;
            end else if (pcIf.branch_en && pcIf.branch_cond) begin
                pc_d = pc_q + offsetExt;
            end else begin
                pc_d = pcPlus1;
            end
        end
    end

    always_ff @(posedge clock_reg or posedge reset) begin
        if (reset) begin
            pc_q           <= RESET_VECTOR;
            sp_q           <= '0;
            errOverflow_q  <= 1'b0;
            errUnderflow_q <= 1'b0;
        end else begin
            pc_q           <= pc_d;
            sp_q           <= sp_d;
            errOverflow_q  <= errOverflow_d;
            errUnderflow_q <= errUnderflow_d;
        end
    end

    // Entry contents are don't-care after reset, so the stack storage carries no reset.
    always_ff @(posedge clock_reg) begin
        if (pushEn) begin
            stack_q[pushIdx] <= pcPlus1;
        end
    end

    assign pcIf.PC            = pc_q;
    assign pcIf.pc_plus1      = pcPlus1;
    assign pcIf.sp            = sp_q;
    assign pcIf.stack_full    = stackFull;
    assign pcIf.stack_empty   = stackEmpty;
    assign pcIf.err_overflow  = errOverflow_q;
    assign pcIf.err_underflow = errUnderflow_q;
endmodule

// File: tb/tb_program_counter_seq.sv
// Directed bench for program_counter_seq: a vector table for the single-cycle behaviour,
// plus hand-written sequences for async reset, stall with unknown controls, and reset during a call.
module tb_program_counter_seq;
    logic clock_reg;
    logic reset;
    int   testsRun;
    int   testsFailed;

    program_counter_seq_if #(.WIDTH(8), .STACK_DEPTH(4), .OFS_WIDTH(8)) pcIf ();

    program_counter_seq #(
        .WIDTH(8), .RESET_VECTOR(8'h00), .STACK_DEPTH(4), .OFS_WIDTH(8)
    ) dut (
        .clock_reg (clock_reg),
        .reset     (reset),
        .pcIf      (pcIf)
    );

    initial clock_reg = 1'b0;
    always #5 clock_reg = ~clock_reg;

    typedef struct {
        logic       stall;
        logic       brEn;
        logic       brCond;
        logic [7:0] ofs;
        logic       jumpEn;
        logic       callEn;
        logic       retEn;
        logic [7:0] target;
        logic [7:0] expPc;
        logic [2:0] expSp;
        logic       expOvf;
        logic       expUdf;
    } vec_t;

    vec_t vecs[$];

    task automatic addVec(input logic st, input logic be, input logic bc, input logic [7:0] ofs,
                          input logic je, input logic ce, input logic re, input logic [7:0] tgt,
                          input logic [7:0] ePc, input logic [2:0] eSp, input logic eOvf, input logic eUdf);
        vec_t v;
        v.stall = st; v.brEn = be; v.brCond = bc; v.ofs = ofs;
        v.jumpEn = je; v.callEn = ce; v.retEn = re; v.target = tgt;
        v.expPc = ePc; v.expSp = eSp; v.expOvf = eOvf; v.expUdf = eUdf;
        vecs.push_back(v);
    endtask

    task automatic setInputs(input logic st, input logic be, input logic bc, input logic [7:0] ofs,
                             input logic je, input logic ce, input logic re, input logic [7:0] tgt);
        pcIf.stall         = st;
        pcIf.branch_en     = be;
        pcIf.branch_cond   = bc;
        pcIf.branch_offset = ofs;
        pcIf.jump_en       = je;
        pcIf.call_en       = ce;
        pcIf.ret_en        = re;
        pcIf.jump_target   = tgt;
    endtask

    task automatic applyStimulus(input logic st, input logic be, input logic bc, input logic [7:0] ofs,
                                 input logic je, input logic ce, input logic re, input logic [7:0] tgt);
        setInputs(st, be, bc, ofs, je, ce, re, tgt);
        @(posedge clock_reg);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAll(input string tag, input logic [7:0] ePc, input logic [2:0] eSp,
                            input logic eOvf, input logic eUdf);
        logic [7:0] ePlus1;
        ePlus1 = ePc + 8'd1;
        checkOutput({tag, ".PC"},            32'(pcIf.PC),            32'(ePc));
        checkOutput({tag, ".pc_plus1"},      32'(pcIf.pc_plus1),      32'(ePlus1));
        checkOutput({tag, ".sp"},            32'(pcIf.sp),            32'(eSp));
        checkOutput({tag, ".stack_full"},    32'(pcIf.stack_full),    32'(eSp == 3'd4));
        checkOutput({tag, ".stack_empty"},   32'(pcIf.stack_empty),   32'(eSp == 3'd0));
        checkOutput({tag, ".err_overflow"},  32'(pcIf.err_overflow),  32'(eOvf));
        checkOutput({tag, ".err_underflow"}, 32'(pcIf.err_underflow), 32'(eUdf));
    endtask

    initial begin
        testsRun    = 0;
        testsFailed = 0;

        // Starts from PC=0x03, sp=0, no errors (state left by the reset sequence below).
        //     st be bc ofs    je ce re tgt     PC     sp ovf udf
        addVec(0, 0, 0, 8'h00, 1, 0, 0, 8'hFE, 8'hFE, 0, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'hFF, 0, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, 8'h10, 8'h10, 0, 0, 0);
        addVec(0, 1, 1, 8'hF0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, 8'h10, 8'h10, 0, 0, 0);
        addVec(0, 1, 0, 8'hF0, 0, 0, 0, 8'h00, 8'h11, 0, 0, 0);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, 8'h05, 8'h05, 0, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 1, 0, 8'h40, 8'h40, 1, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 1, 0, 8'h80, 8'h80, 2, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h41, 1, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h06, 0, 0, 0);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, 8'h00, 8'h00, 0, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 1, 0, 8'h20, 8'h20, 1, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 1, 0, 8'h20, 8'h20, 2, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 1, 0, 8'h20, 8'h20, 3, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 1, 0, 8'h20, 8'h20, 4, 0, 0);
        addVec(0, 0, 0, 8'h00, 0, 1, 0, 8'h20, 8'h20, 4, 1, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h21, 3, 1, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h21, 2, 1, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h21, 1, 1, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h01, 0, 1, 0);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, 8'h30, 8'h30, 0, 1, 0);
        addVec(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h31, 0, 1, 1);
        addVec(0, 1, 1, 8'h05, 1, 1, 0, 8'h50, 8'h50, 1, 1, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 1, 8'h99, 8'h50, 1, 1, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 1, 8'h99, 8'h50, 1, 1, 1);
        addVec(1, 0, 0, 8'h00, 1, 0, 1, 8'h99, 8'h50, 1, 1, 1);
        addVec(0, 0, 0, 8'h00, 1, 0, 1, 8'h99, 8'h32, 0, 1, 1);
        addVec(0, 0, 0, 8'h00, 1, 0, 0, 8'hFF, 8'hFF, 0, 1, 1);
        addVec(0, 0, 0, 8'h00, 0, 1, 0, 8'h10, 8'h10, 1, 1, 1);
        addVec(0, 0, 0, 8'h00, 0, 0, 1, 8'h00, 8'h00, 0, 1, 1);
        addVec(0, 0, 0, 8'h00, 0, 1, 0, 8'h70, 8'h70, 1, 1, 1);
        addVec(0, 0, 0, 8'h00, 0, 1, 1, 8'h44, 8'h01, 0, 1, 1);

        reset = 1'b1;
        setInputs(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        #2;
        checkAll("reset", 8'h00, 0, 0, 0);

        // Jump to 0x37, then pull reset between edges: PC must clear without a clock.
        #1;
        reset = 1'b0;
        setInputs(0, 0, 0, 8'h00, 1, 0, 0, 8'h37);
        @(posedge clock_reg);
        #1;
        checkAll("jump37", 8'h37, 0, 0, 0);
        setInputs(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        #2;
        reset = 1'b1;
        #1;
        checkAll("asyncReset", 8'h00, 0, 0, 0);
        #2;
        reset = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
            checkAll($sformatf("idle%0d", i), 8'(i), 0, 0, 0);
        end

        foreach (vecs[i]) begin
            applyStimulus(vecs[i].stall, vecs[i].brEn, vecs[i].brCond, vecs[i].ofs,
                          vecs[i].jumpEn, vecs[i].callEn, vecs[i].retEn, vecs[i].target);
            checkAll($sformatf("vec%0d", i), vecs[i].expPc, vecs[i].expSp,
                     vecs[i].expOvf, vecs[i].expUdf);
        end

        // Unknown controls under stall must leave every piece of state untouched.
        applyStimulus(1, 1'bx, 1'bx, 8'hxx, 1'bx, 1'bx, 1'bx, 8'hxx);
        checkAll("stallX", 8'h01, 0, 1, 1);

        // Reset in the middle of a call discards the call and clears the sticky flags.
        setInputs(0, 0, 0, 8'h00, 0, 1, 0, 8'h44);
        #2;
        reset = 1'b1;
        #1;
        checkAll("resetDuringCall", 8'h00, 0, 0, 0);
        setInputs(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        #2;
        reset = 1'b0;
        applyStimulus(0, 0, 0, 8'h00, 0, 0, 0, 8'h00);
        checkAll("postReset", 8'h01, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
